// File: rtl/decode_stage.sv
// LEGv8 IF/ID -> ID/EX decode stage.
// Decodes the supported instruction subset into registered control and operand
// fields. A load-use hazard holds the fetch side for one cycle with stall_out.
// A taken-branch flush turns the stage contents into a bubble.
module decode_stage #(
    parameter int ADDR_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              flush,
    output logic              stall_out,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [REG_AW-1:0] id_rd,
    output logic [REG_AW-1:0] id_rn,
    output logic [REG_AW-1:0] id_rm,
    output logic [ADDR_W-1:0] id_imm,
    output logic [ADDR_W-1:0] id_br_offset,
    output logic              id_reg_write,
    output logic              id_alu_src,
    output logic              id_mem_write,
    output logic              id_mem_to_reg,
    output logic              id_set_flags,
    output logic              id_uncond_br,
    output logic              id_cbz,
    output logic              id_blt,
    output logic [2:0]        id_alu_op,
    output logic              id_illegal
);

    // Register index 31 reads as zero, so it can never carry a load-use dependency.
    localparam logic [REG_AW-1:0] XZR = {REG_AW{1'b1}};

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

    // Opcode matches.
    logic is_addi_s, is_adds_s, is_subs_s, is_ldur_s, is_stur_s;
    logic is_b_s, is_blt_s, is_cbz_s;

    assign is_addi_s = (if_instr[31:22] == 10'b1001000100);
    assign is_adds_s = (if_instr[31:21] == 11'b10101011000);
    assign is_subs_s = (if_instr[31:21] == 11'b11101011000);
    assign is_ldur_s = (if_instr[31:21] == 11'b11111000010);
    assign is_stur_s = (if_instr[31:21] == 11'b11111000000);
    assign is_b_s    = (if_instr[31:26] == 6'b000101);
    assign is_blt_s  = (if_instr[31:24] == 8'b01010100) && (if_instr[4:0] == 5'b01011);
    assign is_cbz_s  = (if_instr[31:24] == 8'b10110100);

    // Raw register fields.
    logic [REG_AW-1:0] rd_field_s, rn_field_s, rm_field_s;

    assign rd_field_s = if_instr[4:0];
    assign rn_field_s = if_instr[9:5];
    assign rm_field_s = if_instr[20:16];

    // Decoded (not yet registered) controls and operands.
    logic              d_reg_write_s, d_alu_src_s, d_mem_write_s, d_mem_to_reg_s;
    logic              d_set_flags_s, d_uncond_br_s, d_cbz_s, d_blt_s, d_illegal_s;
    logic [2:0]        d_alu_op_s;
    logic [ADDR_W-1:0] d_imm_s, d_br_offset_s;
    logic [REG_AW-1:0] d_rm_s;
    logic              uses_rn_s, uses_rm_s, uses_rt_s;
    logic              hazard_s;

    // Control decode: one instruction class selected, everything else stays 0.
    always_comb begin
        d_reg_write_s  = 1'b0;
        d_alu_src_s    = 1'b0;
        d_mem_write_s  = 1'b0;
        d_mem_to_reg_s = 1'b0;
        d_set_flags_s  = 1'b0;
        d_uncond_br_s  = 1'b0;
        d_cbz_s        = 1'b0;
        d_blt_s        = 1'b0;
        d_illegal_s    = 1'b0;
        d_alu_op_s     = ALU_PASS_B;
        if (is_addi_s) begin
            d_reg_write_s = 1'b1;
            d_alu_src_s   = 1'b1;
            d_alu_op_s    = ALU_ADD;
        end else if (is_adds_s) begin
            d_reg_write_s = 1'b1;
            d_set_flags_s = 1'b1;
            d_alu_op_s    = ALU_ADD;
        end else if (is_subs_s) begin
            d_reg_write_s = 1'b1;
            d_set_flags_s = 1'b1;
            d_alu_op_s    = ALU_SUB;
        end else if (is_ldur_s) begin
            d_reg_write_s  = 1'b1;
            d_alu_src_s    = 1'b1;
            d_mem_to_reg_s = 1'b1;
            d_alu_op_s     = ALU_ADD;
        end else if (is_stur_s) begin
            d_mem_write_s = 1'b1;
            d_alu_src_s   = 1'b1;
            d_alu_op_s    = ALU_ADD;
        end else if (is_b_s) begin
            d_uncond_br_s = 1'b1;
        end else if (is_blt_s) begin
            d_blt_s = 1'b1;
        end else if (is_cbz_s) begin
            d_cbz_s = 1'b1;
        end else begin
            d_illegal_s = 1'b1;
        end
    end

    // Immediate, branch-offset and Reg2Loc operand selection.
    always_comb begin
        d_imm_s       = {ADDR_W{1'b0}};
        d_br_offset_s = {ADDR_W{1'b0}};
        if (is_addi_s) begin
            d_imm_s = {{(ADDR_W-12){1'b0}}, if_instr[21:10]};
        end else if (is_ldur_s || is_stur_s) begin
            d_imm_s = {{(ADDR_W-9){if_instr[20]}}, if_instr[20:12]};
        end else begin
            d_imm_s = {ADDR_W{1'b0}};
        end
        if (is_b_s) begin
            d_br_offset_s = {{(ADDR_W-28){if_instr[25]}}, if_instr[25:0], 2'b00};
        end else if (is_blt_s || is_cbz_s) begin
            d_br_offset_s = {{(ADDR_W-21){if_instr[23]}}, if_instr[23:5], 2'b00};
        end else begin
            d_br_offset_s = {ADDR_W{1'b0}};
        end
        if (is_stur_s || is_cbz_s) begin
            d_rm_s = rd_field_s;
        end else begin
            d_rm_s = rm_field_s;
        end
    end

    // Load-use hazard: the current instruction reads the register an LDUR in the stage is loading.
    always_comb begin
        uses_rn_s = is_adds_s || is_subs_s || is_addi_s || is_ldur_s || is_stur_s;
        uses_rm_s = is_adds_s || is_subs_s;
        uses_rt_s = is_stur_s || is_cbz_s;
        if (if_valid && !flush && !reset && id_valid && id_mem_to_reg && (id_rd != XZR)) begin
            hazard_s = (uses_rn_s && (rn_field_s == id_rd)) ||
                       (uses_rm_s && (rm_field_s == id_rd)) ||
                       (uses_rt_s && (rd_field_s == id_rd));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign stall_out = hazard_s;

    // ID/EX register: reset, flush, empty fetch or stall load a bubble; otherwise capture the decode.
    always_ff @(posedge clk) begin
        if (reset || flush || !if_valid || hazard_s) begin
            id_valid      <= 1'b0;
            id_pc         <= {ADDR_W{1'b0}};
            id_rd         <= {REG_AW{1'b0}};
            id_rn         <= {REG_AW{1'b0}};
            id_rm         <= {REG_AW{1'b0}};
            id_imm        <= {ADDR_W{1'b0}};
            id_br_offset  <= {ADDR_W{1'b0}};
            id_reg_write  <= 1'b0;
            id_alu_src    <= 1'b0;
            id_mem_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_set_flags  <= 1'b0;
            id_uncond_br  <= 1'b0;
            id_cbz        <= 1'b0;
            id_blt        <= 1'b0;
            id_alu_op     <= 3'b000;
            id_illegal    <= 1'b0;
        end else begin
            id_valid      <= 1'b1;
            id_pc         <= if_pc;
            id_rd         <= rd_field_s;
            id_rn         <= rn_field_s;
            id_rm         <= d_rm_s;
            id_imm        <= d_imm_s;
            id_br_offset  <= d_br_offset_s;
            id_reg_write  <= d_reg_write_s;
            id_alu_src    <= d_alu_src_s;
            id_mem_write  <= d_mem_write_s;
            id_mem_to_reg <= d_mem_to_reg_s;
            id_set_flags  <= d_set_flags_s;
            id_uncond_br  <= d_uncond_br_s;
            id_cbz        <= d_cbz_s;
            id_blt        <= d_blt_s;
            id_alu_op     <= d_alu_op_s;
            id_illegal    <= d_illegal_s;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage; expected values are hand-encoded.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        flush;
    logic        stall_out;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [4:0]  id_rd, id_rn, id_rm;
    logic [63:0] id_imm, id_br_offset;
    logic        id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg, id_set_flags;
    logic        id_uncond_br, id_cbz, id_blt, id_illegal;
    logic [2:0]  id_alu_op;

    int vectors = 0;
    int miscompares = 0;

    // Packed controls: valid rw alu_src mw mtr sf ub cbz blt illegal | alu_op
    logic [12:0] ctl;
    assign ctl = {id_valid, id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg,
                  id_set_flags, id_uncond_br, id_cbz, id_blt, id_illegal, id_alu_op};

    localparam logic [31:0] ADDI_1_2_5    = 32'h9100_1441;
    localparam logic [31:0] STUR_3_4_M8   = 32'hF81F_8083;
    localparam logic [31:0] LDUR_5_6      = 32'hF840_00C5;
    localparam logic [31:0] ADDS_7_5_8    = 32'hAB08_00A7;
    localparam logic [31:0] LDUR_31_6     = 32'hF840_00DF;
    localparam logic [31:0] ADDS_7_31_8   = 32'hAB08_03E7;
    localparam logic [31:0] SUBS_1_2_3    = 32'hEB03_0041;
    localparam logic [31:0] BLT_M2        = 32'h54FF_FFCB;
    localparam logic [31:0] BCOND_EQ_M2   = 32'h54FF_FFC0;
    localparam logic [31:0] B_M1          = 32'h17FF_FFFF;
    localparam logic [31:0] LDUR_9_6      = 32'hF840_00C9;
    localparam logic [31:0] CBZ_9_4       = 32'hB400_0089;

    decode_stage #(.ADDR_W(64), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .stall_out(stall_out), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_imm(id_imm),
        .id_br_offset(id_br_offset), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_set_flags(id_set_flags), .id_uncond_br(id_uncond_br), .id_cbz(id_cbz),
        .id_blt(id_blt), .id_alu_op(id_alu_op), .id_illegal(id_illegal)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [63:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        present(ADDI_1_2_5, 64'h40);
        step();
        step();
        vectors++;
        if (ctl !== 13'd0) begin miscompares++; $display("FAIL reset_ctl: got %b expected %b", ctl, 13'd0); end
        vectors++;
        if ({id_pc, id_imm, id_br_offset, id_rd, id_rn, id_rm} !== 207'd0) begin
            miscompares++; $display("FAIL reset_fields: got pc %h imm %h rd %0d", id_pc, id_imm, id_rd);
        end
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        present(ADDI_1_2_5, 64'h10);
        step();
        vectors++;
        if (ctl !== {10'b1110000000, 3'b010}) begin miscompares++; $display("FAIL addi_ctl: got %b expected %b", ctl, {10'b1110000000, 3'b010}); end
        vectors++;
        if ({id_rd, id_rn} !== {5'd1, 5'd2}) begin miscompares++; $display("FAIL addi_regs: got rd %0d rn %0d expected 1 2", id_rd, id_rn); end
        vectors++;
        if (id_imm !== 64'd5) begin miscompares++; $display("FAIL addi_imm: got %h expected 5", id_imm); end
        vectors++;
        if (id_pc !== 64'h10) begin miscompares++; $display("FAIL addi_pc: got %h expected 10", id_pc); end
    endtask

    task automatic test_subs();
        present(SUBS_1_2_3, 64'h14);
        step();
        vectors++;
        if (ctl !== {10'b1100010000, 3'b011}) begin miscompares++; $display("FAIL subs_ctl: got %b expected %b", ctl, {10'b1100010000, 3'b011}); end
        vectors++;
        if (id_rm !== 5'd3) begin miscompares++; $display("FAIL subs_rm: got %0d expected 3", id_rm); end
    endtask

    task automatic test_stur();
        present(STUR_3_4_M8, 64'h18);
        step();
        vectors++;
        if (ctl !== {10'b1011000000, 3'b010}) begin miscompares++; $display("FAIL stur_ctl: got %b expected %b", ctl, {10'b1011000000, 3'b010}); end
        vectors++;
        if ({id_rm, id_rn} !== {5'd3, 5'd4}) begin miscompares++; $display("FAIL stur_regs: got rm %0d rn %0d expected 3 4", id_rm, id_rn); end
        vectors++;
        if (id_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin miscompares++; $display("FAIL stur_imm: got %h expected fffffffffffffff8", id_imm); end
    endtask

    task automatic test_load_use();
        present(LDUR_5_6, 64'h20);
        step();
        vectors++;
        if (ctl !== {10'b1110100000, 3'b010}) begin miscompares++; $display("FAIL ldur_ctl: got %b expected %b", ctl, {10'b1110100000, 3'b010}); end
        present(ADDS_7_5_8, 64'h24);
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b expected 1", stall_out); end
        step();
        vectors++;
        if (id_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble: got valid %b expected 0", id_valid); end
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL lu_one_cycle: got stall %b expected 0", stall_out); end
        step();
        vectors++;
        if (ctl !== {10'b1100010000, 3'b010}) begin miscompares++; $display("FAIL lu_adds_ctl: got %b expected %b", ctl, {10'b1100010000, 3'b010}); end
        vectors++;
        if ({id_rn, id_rm, id_pc} !== {5'd5, 5'd8, 64'h24}) begin miscompares++; $display("FAIL lu_adds_fields: got rn %0d rm %0d pc %h", id_rn, id_rm, id_pc); end
    endtask

    task automatic test_load_xzr();
        present(LDUR_31_6, 64'h30);
        step();
        present(ADDS_7_31_8, 64'h34);
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL xzr_stall: got %b expected 0", stall_out); end
        step();
        vectors++;
        if ({id_valid, id_rn} !== {1'b1, 5'd31}) begin miscompares++; $display("FAIL xzr_adds: got valid %b rn %0d expected 1 31", id_valid, id_rn); end
    endtask

    task automatic test_cbz();
        present(LDUR_9_6, 64'h40);
        step();
        present(CBZ_9_4, 64'h44);
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL cbz_rt_stall: got %b expected 1", stall_out); end
        step();
        step();
        vectors++;
        if (ctl !== {10'b1000000100, 3'b000}) begin miscompares++; $display("FAIL cbz_ctl: got %b expected %b", ctl, {10'b1000000100, 3'b000}); end
        vectors++;
        if ({id_rm, id_br_offset} !== {5'd9, 64'd16}) begin miscompares++; $display("FAIL cbz_fields: got rm %0d off %h expected 9 10", id_rm, id_br_offset); end
    endtask

    task automatic test_b();
        present(B_M1, 64'h50);
        step();
        vectors++;
        if (ctl !== {10'b1000001000, 3'b000}) begin miscompares++; $display("FAIL b_ctl: got %b expected %b", ctl, {10'b1000001000, 3'b000}); end
        vectors++;
        if (id_br_offset !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL b_off: got %h expected fffffffffffffffc", id_br_offset); end
    endtask

    task automatic test_blt_flush();
        present(BLT_M2, 64'h60);
        step();
        vectors++;
        if (ctl !== {10'b1000000010, 3'b000}) begin miscompares++; $display("FAIL blt_ctl: got %b expected %b", ctl, {10'b1000000010, 3'b000}); end
        vectors++;
        if (id_br_offset !== 64'hFFFF_FFFF_FFFF_FFF8) begin miscompares++; $display("FAIL blt_off: got %h expected fffffffffffffff8", id_br_offset); end
        flush = 1'b1;
        present(ADDI_1_2_5, 64'h64);
        step();
        vectors++;
        if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush_bubble: got valid %b expected 0", id_valid); end
        flush = 1'b0;
        present(LDUR_5_6, 64'h70);
        step();
        flush = 1'b1;
        present(ADDS_7_5_8, 64'h74);
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL flush_no_stall: got %b expected 0", stall_out); end
        step();
        vectors++;
        if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush_hazard_bubble: got valid %b expected 0", id_valid); end
        flush = 1'b0;
    endtask

    task automatic test_illegal();
        present(32'h0000_0000, 64'h80);
        step();
        vectors++;
        if (ctl !== {10'b1000000001, 3'b000}) begin miscompares++; $display("FAIL illegal_ctl: got %b expected %b", ctl, {10'b1000000001, 3'b000}); end
        present(BCOND_EQ_M2, 64'h84);
        step();
        vectors++;
        if ({id_illegal, id_blt} !== 2'b10) begin miscompares++; $display("FAIL bcond_illegal: got ill %b blt %b expected 1 0", id_illegal, id_blt); end
        if_valid = 1'b0;
        present(ADDI_1_2_5, 64'h88);
        if_valid = 1'b0;
        step();
        vectors++;
        if (id_valid !== 1'b0) begin miscompares++; $display("FAIL invalid_bubble: got valid %b expected 0", id_valid); end
    endtask

    task automatic test_reset_during_stall();
        present(LDUR_5_6, 64'h90);
        step();
        present(ADDS_7_5_8, 64'h94);
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL rst_pre_stall: got %b expected 1", stall_out); end
        reset = 1'b1;
        #1;
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL rst_stall_low: got %b expected 0", stall_out); end
        step();
        vectors++;
        if ({ctl, id_pc, id_rd, id_rn, id_rm, id_imm, id_br_offset} !== 220'd0) begin
            miscompares++; $display("FAIL rst_clear: got ctl %b pc %h rd %0d imm %h", ctl, id_pc, id_rd, id_imm);
        end
        reset = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 64'd0;
        test_reset();
        test_addi();
        test_subs();
        test_stur();
        test_load_use();
        test_load_xzr();
        test_cbz();
        test_b();
        test_blt_flush();
        test_illegal();
        test_reset_during_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID-to-EX decode stage for the LEGv8 pipelined core.
- Consumes the 32-bit word from instructmem and its fetch address from program_counter.
- Decodes the supported subset into registered ID/EX control and operand fields.
- Detects load-use hazards and drives stall_out back to program_counter; flush (branch taken) squashes into a bubble.

Parameters:
- ADDR_W, 64, width of PC and sign-extended immediates.
- REG_AW, 5, register index width; index 31 is XZR.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  if_instr/if_pc hold a real fetched instruction.
- if_instr  in  32  instruction word from instructmem.
- if_pc  in  ADDR_W  address of if_instr.
- flush  in  1  branch resolved taken downstream; squash current decode.
- stall_out  out  1  combinational; program_counter holds PC and if_* are re-presented next cycle.
- id_valid  out  1  ID/EX register holds a real instruction.
- id_pc  out  ADDR_W  registered if_pc.
- id_rd  out  5  Rd/Rt field, instr[4:0].
- id_rn  out  5  instr[9:5].
- id_rm  out  5  Reg2Loc-selected second read register.
- id_imm  out  ADDR_W  sign/zero-extended data immediate.
- id_br_offset  out  ADDR_W  sign-extended branch offset, already shifted left by 2.
- id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg, id_set_flags  out  1 each  datapath controls.
- id_uncond_br, id_cbz, id_blt  out  1 each  branch-type controls.
- id_alu_op  out  3  000 pass B, 010 add, 011 subtract.
- id_illegal  out  1  unrecognised opcode.

Behaviour:
- Reset: every registered output is 0, including id_valid. stall_out is 0 while reset is high.
- Latency: 1 cycle. Inputs sampled at posedge N appear on id_* after that edge.
- Decode rules. All unlisted controls are 0. id_alu_op is 000 unless stated.
  - ADDI, instr[31:22]=1001000100: reg_write, alu_src, alu_op=010. id_imm = zero-extended instr[21:10].
  - ADDS, instr[31:21]=10101011000: reg_write, set_flags, alu_op=010.
  - SUBS, instr[31:21]=11101011000: reg_write, set_flags, alu_op=011.
  - LDUR, instr[31:21]=11111000010: reg_write, alu_src, mem_to_reg, alu_op=010. id_imm = sign-extended instr[20:12].
  - STUR, instr[31:21]=11111000000: mem_write, alu_src, alu_op=010. id_imm = sign-extended instr[20:12]. Reg2Loc applies.
  - B, instr[31:26]=000101: uncond_br. id_br_offset = sext(instr[25:0])<<2.
  - B.LT, instr[31:24]=01010100 and instr[4:0]=01011: blt. id_br_offset = sext(instr[23:5])<<2.
  - CBZ, instr[31:24]=10110100: cbz, alu_op=000. id_br_offset as B.LT. Reg2Loc applies.
- Reg2Loc: id_rm = instr[4:0] for STUR and CBZ; otherwise id_rm = instr[20:16].
- Illegal: any other encoding with if_valid=1 sets id_valid=1 and id_illegal=1. All write and branch controls are 0.
- Source registers per instruction:
  - ADDS/SUBS: Rn, Rm.
  - ADDI/LDUR: Rn.
  - STUR: Rn, Rt.
  - CBZ: Rt.
  - B, B.LT: none.
- Load-use hazard: stall_out=1 when all of the following hold:
  - if_valid=1 and flush=0;
  - the registered stage holds a valid LDUR (id_valid & id_mem_to_reg);
  - id_rd != 31;
  - id_rd equals a source register of the current instruction.
- On a stall edge: the ID/EX register loads a bubble (id_valid=0, all controls 0; id_pc and fields are don't-care). if_* are not consumed. The hazard clears the next cycle because a bubble is now in the stage, so one stall cycle is inserted per hazard.
- Flush: flush=1 at an edge loads a bubble regardless of if_valid or hazard. stall_out=0 whenever flush=1.
- if_valid=0 with no flush: load a bubble.
- Reset mid-operation: reset overrides flush and stall, and clears the stage to a bubble on that edge.

Test Plan:
- Reset then if_valid=1, if_instr=ADDI X1,X2,#5 (0x91001441), if_pc=0x10 -> one cycle later: id_valid=1, id_rd=1, id_rn=2, id_imm=5, alu_src=1, reg_write=1, alu_op=010, id_pc=0x10.
- STUR X3,[X4,#-8] (0xF81F8083) -> id_rm=3, id_imm=0xFFFF_FFFF_FFFF_FFF8, mem_write=1, reg_write=0.
- LDUR X5,[X6,#0] followed by ADDS X7,X5,X8 -> stall_out=1 for exactly one cycle. A bubble appears (id_valid=0), then ADDS decodes with id_rn=5.
- LDUR X31,[X6,#0] followed by ADDS X7,X31,X8 -> stall_out stays 0.
- B.LT #-2 (cond field 01011, imm19=-2) -> id_blt=1, id_br_offset=0xFFFF_FFFF_FFFF_FFF8. Assert flush on the next edge -> id_valid=0 after that edge.
- Illegal word 0x00000000 -> id_illegal=1, id_reg_write=0, id_mem_write=0. Assert reset during a hazard stall -> all id_* = 0 and stall_out = 0.
